logc_rr_sched: RTL and testbench
================================

Name: logc_rr_sched

Overview:
- Round-robin scheduler that shares one log-compression integer/normalisation unit (int_calc) among NUM_CH beamformed sample channels.
- Accepts one sample at a time from the winning channel and issues it to the shared unit.
- Captures the unit's (int_part, data_out) result and returns it to the originating channel tagged with the channel index.
- Sits between per-channel envelope outputs and the shared int_calc in the log-compression stage; exactly one transaction is in flight at any time.

Parameters:
- NUM_CH, 4, number of requesting channels (2..16).
- DATA_WIDTH, 16, sample width.
- FRAC_WIDTH, 16, fractional width of the unit result.
- NORM_WIDTH, FRAC_WIDTH+1, width of the normalised result.
- SHIFT_WIDTH, $clog2(DATA_WIDTH), width of int_part.
- CH_WIDTH, $clog2(NUM_CH), width of the channel tag.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- chan_en  in  NUM_CH  per-channel enable; a masked channel is never granted
- req_valid  in  NUM_CH  per-channel sample valid
- req_ready  out  NUM_CH  per-channel accept; at most one bit high
- req_data  in  NUM_CH*DATA_WIDTH  flattened samples; channel k at [k*DATA_WIDTH +: DATA_WIDTH]
- calc_in_valid  out  1  sample valid to the shared unit
- calc_in_ready  in  1  shared unit ready
- calc_data  out  DATA_WIDTH  sample to the shared unit
- calc_out_valid  in  1  result valid from the unit (may be a 1-cycle pulse)
- calc_out_ready  out  1  result ready to the unit
- calc_int_part  in  SHIFT_WIDTH  unit integer part
- calc_data_out  in  NORM_WIDTH  unit normalised mantissa
- rsp_valid  out  NUM_CH  per-channel result valid; one-hot or zero
- rsp_ready  in  NUM_CH  per-channel result accept
- rsp_chan  out  CH_WIDTH  channel tag of the current result
- rsp_int_part  out  SHIFT_WIDTH  result integer part
- rsp_data  out  NORM_WIDTH  result mantissa
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset values (asynchronous):
  - state=IDLE, rr_ptr=0.
  - All req_ready, rsp_valid, calc_in_valid and calc_out_ready are 0.
  - calc_data, rsp_chan, rsp_int_part and rsp_data are 0; busy=0.
- Eligible set: req_valid & chan_en.
- IDLE:
  - If the eligible set is nonzero, the winner is the first eligible channel scanning rr_ptr, rr_ptr+1, … modulo NUM_CH.
  - req_ready[winner]=1 combinationally in the same cycle; at the clock edge, req_data[winner] is latched into calc_data, the winner is latched into cur_ch, and the state becomes ISSUE.
  - req_ready is 0 in every other state.
- ISSUE:
  - calc_in_valid=1, held with stable calc_data until calc_in_ready=1.
  - On that edge, go to WAIT_RES and drop calc_in_valid.
- WAIT_RES:
  - calc_out_ready=1.
  - On calc_out_valid=1, latch calc_int_part and calc_data_out into rsp_int_part/rsp_data, set rsp_chan=cur_ch, and go to RETURN.
  - calc_out_valid outside WAIT_RES is ignored.
- RETURN:
  - rsp_valid[cur_ch]=1, with outputs stable until rsp_ready[cur_ch]=1.
  - On that edge: rsp_valid clears, rr_ptr=(cur_ch+1) mod NUM_CH, state=IDLE.
  - rsp_ready on other channels is ignored.
- The IDLE→ISSUE edge after a return occurs no earlier than the cycle following RETURN exit; there is no back-to-back overlap.
- Minimum scheduler overhead: 1 accept cycle + 1 issue cycle + 1 return cycle, plus the unit's latency.
- chan_en changes:
  - A change mid-transaction does not abort the in-flight sample.
  - The change is applied only at the next IDLE arbitration.
- rr_ptr wrap: from NUM_CH-1 it goes to 0; a single eligible channel is granted on every arbitration.
- Reset mid-operation: immediate return to IDLE with all valids/readies low; any in-flight result is discarded.
- Arithmetic: the block does none; results pass through bit-exact.

Optional Feature:
- Macro: LOGC_RR_SCHED_STATS_EN.
- With the macro defined:
  - Added ports: stat_clear (input, 1) and stat_grants (output, NUM_CH*16).
  - stat_grants holds per-channel 16-bit saturating counters, incremented on each IDLE grant and held at 16'hFFFF.
  - stat_clear synchronously zeroes all counters; if stat_clear and a grant coincide, clear wins.
  - Counters reset to 0.
- Without the macro: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Single request: ch2 req 0x0100, stub unit returns int_part=8, data_out=0x10000 → rsp_valid=4'b0100, rsp_chan=2, rsp_int_part=8, rsp_data=0x10000.
- Fairness: all 4 channels hold req_valid for 8 transactions, rsp_ready=1 → grant order 0,1,2,3,0,1,2,3.
- Masking: chan_en=4'b1011, all valid → ch2 never gets req_ready; order 0,1,3,0.
- Backpressure:
  - calc_in_ready=0 for 5 cycles → calc_in_valid and calc_data stable, then handshake.
  - rsp_ready=0 for 7 cycles → rsp outputs stable, no new req_ready.
- Pulse result: calc_out_valid high for one cycle only → result captured; a spurious pulse in IDLE is ignored (no rsp_valid).
- Reset in WAIT_RES: assert reset asynchronously → busy=0, all valids 0 immediately; a subsequent request from ch1 proceeds normally with rr_ptr=0.

Source files
------------

// File: rtl/logc_rr_sched.sv
// rtl/logc_rr_sched.sv - round-robin sharing of one log-compression int_calc unit among NUM_CH channels
// Optional grant statistics: define LOGC_RR_SCHED_STATS_EN.
module logc_rr_sched #(
    parameter int NUM_CH      = 4,
    parameter int DATA_WIDTH  = 16,
    parameter int FRAC_WIDTH  = 16,
    parameter int NORM_WIDTH  = FRAC_WIDTH + 1,
    parameter int SHIFT_WIDTH = $clog2(DATA_WIDTH),
    parameter int CH_WIDTH    = $clog2(NUM_CH)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_CH-1:0]            chan_en,
    input  logic [NUM_CH-1:0]            req_valid,
    output logic [NUM_CH-1:0]            req_ready,
    input  logic [NUM_CH*DATA_WIDTH-1:0] req_data,
    output logic                         calc_in_valid,
    input  logic                         calc_in_ready,
    output logic [DATA_WIDTH-1:0]        calc_data,
    input  logic                         calc_out_valid,
    output logic                         calc_out_ready,
    input  logic [SHIFT_WIDTH-1:0]       calc_int_part,
    input  logic [NORM_WIDTH-1:0]        calc_data_out,
    output logic [NUM_CH-1:0]            rsp_valid,
    input  logic [NUM_CH-1:0]            rsp_ready,
    output logic [CH_WIDTH-1:0]          rsp_chan,
    output logic [SHIFT_WIDTH-1:0]       rsp_int_part,
    output logic [NORM_WIDTH-1:0]        rsp_data,
    output logic                         busy
`ifdef LOGC_RR_SCHED_STATS_EN
    ,
    input  logic                         stat_clear,
    output logic [NUM_CH*16-1:0]         stat_grants
`endif
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RES = 2'd2,
        RETURN   = 2'd3
    } state_t;

    state_t                state, state_nxt;
    logic [CH_WIDTH-1:0]   rr_ptr;
    logic [CH_WIDTH-1:0]   cur_ch;
    logic [CH_WIDTH-1:0]   win_idx;
    logic [CH_WIDTH-1:0]   cand;
    logic                  win_found;
    logic [NUM_CH-1:0]     eligible;
    logic                  grant;

    assign eligible = req_valid & chan_en;
    assign busy     = (state != IDLE);
    assign grant    = (state == IDLE) && win_found;

    // Scan from the highest offset down so the channel closest to rr_ptr wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            cand = CH_WIDTH'((int'(rr_ptr) + i) % NUM_CH);
            if (eligible[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        req_ready      = '0;
        calc_in_valid  = 1'b0;
        calc_out_ready = 1'b0;
        rsp_valid      = '0;
        case (state)
            IDLE: begin
                // Gated by reset so no accept is advertised while reset is held.
                if (win_found && !reset) begin
                    req_ready = NUM_CH'(1) << win_idx;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                calc_in_valid = 1'b1;
                if (calc_in_ready) state_nxt = WAIT_RES;
            end
            WAIT_RES: begin
                calc_out_ready = 1'b1;
                if (calc_out_valid) state_nxt = RETURN;
            end
            RETURN: begin
                rsp_valid = NUM_CH'(1) << cur_ch;
                if (rsp_ready[cur_ch]) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr       <= '0;
            cur_ch       <= '0;
            calc_data    <= '0;
            rsp_chan     <= '0;
            rsp_int_part <= '0;
            rsp_data     <= '0;
        end else begin
            if (grant) begin
                calc_data <= req_data[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
                cur_ch    <= win_idx;
            end
            if (state == WAIT_RES && calc_out_valid) begin
                rsp_int_part <= calc_int_part;
                rsp_data     <= calc_data_out;
                rsp_chan     <= cur_ch;
            end
            if (state == RETURN && rsp_ready[cur_ch]) begin
                rr_ptr <= (cur_ch == CH_WIDTH'(NUM_CH - 1)) ? '0 : cur_ch + 1'b1;
            end
        end
    end

`ifdef LOGC_RR_SCHED_STATS_EN
    logic [15:0] grant_cnt [NUM_CH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_CH; k++) grant_cnt[k] <= '0;
        end else if (stat_clear) begin
            for (int k = 0; k < NUM_CH; k++) grant_cnt[k] <= '0;
        end else if (grant && grant_cnt[win_idx] != 16'hFFFF) begin
            grant_cnt[win_idx] <= grant_cnt[win_idx] + 16'd1;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_stat
        assign stat_grants[g*16 +: 16] = grant_cnt[g];
    end
`endif

endmodule

// File: tb/tb_logc_rr_sched.sv
// tb/tb_logc_rr_sched.sv - directed self-checking bench for logc_rr_sched
module tb_logc_rr_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  chan_en;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [63:0] req_data;
    logic        calc_in_valid;
    logic        calc_in_ready;
    logic [15:0] calc_data;
    logic        calc_out_valid;
    logic        calc_out_ready;
    logic [3:0]  calc_int_part;
    logic [16:0] calc_data_out;
    logic [3:0]  rsp_valid;
    logic [3:0]  rsp_ready;
    logic [1:0]  rsp_chan;
    logic [3:0]  rsp_int_part;
    logic [16:0] rsp_data;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    logc_rr_sched dut (
        .clk            (clk),
        .reset          (rst),
        .chan_en        (chan_en),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_data       (req_data),
        .calc_in_valid  (calc_in_valid),
        .calc_in_ready  (calc_in_ready),
        .calc_data      (calc_data),
        .calc_out_valid (calc_out_valid),
        .calc_out_ready (calc_out_ready),
        .calc_int_part  (calc_int_part),
        .calc_data_out  (calc_data_out),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_chan       (rsp_chan),
        .rsp_int_part   (rsp_int_part),
        .rsp_data       (rsp_data),
        .busy           (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entered at negedge+1 in IDLE with the request inputs already applied.
    task automatic run_txn(input int ch, input logic [15:0] d, input logic [3:0] ip,
                           input logic [16:0] dout, input int in_stall, input int lat,
                           input int rsp_stall);
        logic [3:0] oh;
        oh = 4'b0001 << ch;
        chk("grant", req_ready, oh);
        @(negedge clk); #1;
        chk("issue_valid", calc_in_valid, 1);
        chk("issue_data", calc_data, d);
        chk("issue_no_accept", req_ready, 0);
        for (int i = 0; i < in_stall; i++) begin
            @(negedge clk); #1;
            chk("stall_valid", calc_in_valid, 1);
            chk("stall_data", calc_data, d);
        end
        calc_in_ready = 1'b1;
        @(negedge clk);
        calc_in_ready = 1'b0;
        #1;
        chk("wait_in_valid_low", calc_in_valid, 0);
        chk("wait_out_ready", calc_out_ready, 1);
        for (int i = 0; i < lat; i++) @(negedge clk);
        calc_out_valid = 1'b1;
        calc_int_part  = ip;
        calc_data_out  = dout;
        @(negedge clk);
        calc_out_valid = 1'b0;
        calc_int_part  = ~ip;
        calc_data_out  = ~dout;
        #1;
        chk("rsp_valid", rsp_valid, oh);
        chk("rsp_chan", rsp_chan, ch);
        chk("rsp_int_part", rsp_int_part, ip);
        chk("rsp_data", rsp_data, dout);
        chk("ret_out_ready_low", calc_out_ready, 0);
        rsp_ready = ~oh;
        for (int i = 0; i < rsp_stall; i++) begin
            @(negedge clk); #1;
            chk("hold_rsp_valid", rsp_valid, oh);
            chk("hold_rsp_data", rsp_data, dout);
            chk("hold_no_accept", req_ready, 0);
        end
        rsp_ready = oh;
        @(negedge clk);
        rsp_ready = 4'b0;
        #1;
        chk("done_busy", busy, 0);
        chk("done_rsp_valid", rsp_valid, 0);
    endtask

    initial begin
        rst            = 1'b1;
        chan_en        = 4'hF;
        req_valid      = 4'b0;
        req_data       = '0;
        calc_in_ready  = 1'b0;
        calc_out_valid = 1'b0;
        calc_int_part  = '0;
        calc_data_out  = '0;
        rsp_ready      = 4'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_calc_in_valid", calc_in_valid, 0);
        chk("rst_calc_out_ready", calc_out_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_calc_data", calc_data, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_int_part", rsp_int_part, 0);
        @(negedge clk);
        rst = 1'b0;

        // Single request on ch2; rr_ptr becomes 3.
        req_data  = {16'h0000, 16'h0100, 16'h0000, 16'h0000};
        req_valid = 4'b0100;
        #1;
        run_txn(2, 16'h0100, 4'd8, 17'h10000, 0, 0, 0);

        // Fairness starting from rr_ptr=3.
        req_data  = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
        req_valid = 4'b1111;
        #1;
        run_txn(3, 16'hA003, 4'd1, 17'h00011, 0, 0, 0);
        run_txn(0, 16'hA000, 4'd2, 17'h00022, 0, 1, 0);
        run_txn(1, 16'hA001, 4'd3, 17'h00033, 0, 0, 0);
        run_txn(2, 16'hA002, 4'd4, 17'h00044, 0, 2, 0);
        run_txn(3, 16'hA003, 4'd5, 17'h00055, 0, 0, 0);
        run_txn(0, 16'hA000, 4'd6, 17'h00066, 0, 0, 0);
        run_txn(1, 16'hA001, 4'd7, 17'h00077, 0, 0, 0);
        run_txn(2, 16'hA002, 4'd9, 17'h1FFFF, 0, 0, 0);

        // Masking ch2, starting from rr_ptr=3.
        chan_en = 4'b1011;
        #1;
        run_txn(3, 16'hA003, 4'd10, 17'h00100, 0, 0, 0);
        run_txn(0, 16'hA000, 4'd11, 17'h00200, 0, 0, 0);
        run_txn(1, 16'hA001, 4'd12, 17'h00300, 0, 0, 0);
        run_txn(3, 16'hA003, 4'd13, 17'h00400, 0, 0, 0);

        // Backpressure on both handshakes; rr_ptr=0 so ch0 wins.
        run_txn(0, 16'hA000, 4'd14, 17'h12345, 5, 3, 7);

        // Spurious unit pulse in IDLE must be ignored.
        req_valid      = 4'b0;
        calc_out_valid = 1'b1;
        calc_int_part  = 4'd15;
        calc_data_out  = 17'h0ABCD;
        @(negedge clk);
        calc_out_valid = 1'b0;
        #1;
        chk("spurious_busy", busy, 0);
        chk("spurious_rsp_valid", rsp_valid, 0);
        chk("spurious_rsp_data", rsp_data, 17'h12345);

        // Move rr_ptr to 3 via ch2, then reset with ch2 in flight.
        chan_en   = 4'hF;
        req_valid = 4'b0100;
        #1;
        run_txn(2, 16'hA002, 4'd1, 17'h00001, 0, 0, 0);
        #1;
        chk("pre_rst_grant", req_ready, 4'b0100);
        @(negedge clk);
        calc_in_ready = 1'b1;
        @(negedge clk);
        calc_in_ready = 1'b0;
        #1;
        chk("pre_rst_wait", calc_out_ready, 1);
        req_valid = 4'b1010;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_calc_out_ready", calc_out_ready, 0);
        chk("arst_calc_in_valid", calc_in_valid, 0);
        chk("arst_rsp_valid", rsp_valid, 0);
        chk("arst_req_ready", req_ready, 0);
        @(negedge clk);
        calc_out_valid = 1'b1;
        @(negedge clk);
        calc_out_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("post_rst_rsp_valid", rsp_valid, 0);
        // rr_ptr back at 0: ch1 beats ch3.
        run_txn(1, 16'hA001, 4'd6, 17'h0F0F0, 0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
